// File: rtl/music_sequencer.sv
// music_sequencer
// ---------------
// Plays note tracks out of an external note ROM. The current game scene and
// the boss flag pick a track. Each ROM word is one beat: a tone frequency,
// 0 for a rest, or 32'hFFFFFFFF as the end-of-track marker. Tracks 0-2 loop.
// Tracks 3-4 play once and then park in DONE. Any track change resets the
// sequencer and starts a silent gap of GAP_BEATS beats before the first note.
//
// Ports
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous, active-high reset
//   scene    in   2  00 start, 01 game, 10 win, 11 lose
//   boss     in   1  boss phase flag, only meaningful in the game scene
//   rom_addr out  8  {track, note_idx}, combinational
//   rom_data in  32  ROM word, valid one cycle after rom_addr
//   freq     out 32  registered tone frequency, 0 = silence
//   track    out  3  registered active track (0 start .. 4 lose)
//   done     out  1  registered, high while a one-shot track has finished
module music_sequencer #(
   parameter int unsigned BEAT_CYCLES = 32'd12500000,
   parameter int unsigned GAP_BEATS   = 32'd2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  scene,
   input  logic        boss,
   output logic [7:0]  rom_addr,
   input  logic [31:0] rom_data,
   output logic [31:0] freq,
   output logic [2:0]  track,
   output logic        done
);

   localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 32'd1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_BEATS - 32'd1);
   localparam logic [31:0] EOT_WORD  = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_GAP   = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_PLAY  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t      state_r,    state_s;
   logic [2:0]  track_r,    track_s;
   logic [4:0]  note_idx_r, note_idx_s;
   logic [31:0] beat_cnt_r, beat_cnt_s;
   logic [31:0] gap_cnt_r,  gap_cnt_s;
   logic [31:0] freq_r,     freq_s;
   logic        done_r,     done_s;

   logic [2:0]  track_sel_s;
   logic        is_loop_s;
   logic        beat_end_s;
   logic        note_last_s;

   // Map scene/boss to the requested track.
   always_comb begin
      track_sel_s = 3'd0;
      case (scene)
         2'b00:   track_sel_s = 3'd0;
         2'b01:   track_sel_s = boss ? 3'd2 : 3'd1;
         2'b10:   track_sel_s = 3'd3;
         2'b11:   track_sel_s = 3'd4;
         default: track_sel_s = 3'd0;
      endcase
   end

   assign is_loop_s   = (track_r <= 3'd2);
   assign beat_end_s  = (beat_cnt_r == BEAT_LAST);
   assign note_last_s = (note_idx_r == 5'd31);

   assign rom_addr = {track_r, note_idx_r};
   assign freq     = freq_r;
   assign track    = track_r;
   assign done     = done_r;

   // Next-state and next-value logic. A track change overrides everything.
   always_comb begin
      state_s    = state_r;
      track_s    = track_r;
      note_idx_s = note_idx_r;
      beat_cnt_s = beat_cnt_r;
      gap_cnt_s  = gap_cnt_r;
      freq_s     = freq_r;
      done_s     = done_r;

      if (track_sel_s != track_r) begin
         state_s    = ST_GAP;
         track_s    = track_sel_s;
         note_idx_s = 5'd0;
         beat_cnt_s = 32'd0;
         gap_cnt_s  = 32'd0;
         freq_s     = 32'd0;
         done_s     = 1'b0;
      end else begin
         case (state_r)
            ST_GAP: begin
               freq_s = 32'd0;
               if (beat_end_s) begin
                  beat_cnt_s = 32'd0;
                  if (gap_cnt_r == GAP_LAST) begin
                     gap_cnt_s = 32'd0;
                     state_s   = ST_FETCH;
                  end else begin
                     gap_cnt_s = gap_cnt_r + 32'd1;
                  end
               end else begin
                  beat_cnt_s = beat_cnt_r + 32'd1;
               end
            end
            // The ROM sees the address during FETCH and answers during LOAD.
            ST_FETCH: begin
               state_s = ST_LOAD;
            end
            ST_LOAD: begin
               if (rom_data != EOT_WORD) begin
                  freq_s     = rom_data;
                  beat_cnt_s = 32'd0;
                  state_s    = ST_PLAY;
               end else if (is_loop_s) begin
                  // Wrap straight to the first note; no gap, freq held.
                  note_idx_s = 5'd0;
                  state_s    = ST_FETCH;
               end else begin
                  freq_s  = 32'd0;
                  done_s  = 1'b1;
                  state_s = ST_DONE;
               end
            end
            ST_PLAY: begin
               if (beat_end_s) begin
                  beat_cnt_s = 32'd0;
                  if (!note_last_s) begin
                     note_idx_s = note_idx_r + 5'd1;
                     state_s    = ST_FETCH;
                  end else if (is_loop_s) begin
                     note_idx_s = 5'd0;
                     state_s    = ST_FETCH;
                  end else begin
                     freq_s  = 32'd0;
                     done_s  = 1'b1;
                     state_s = ST_DONE;
                  end
               end else begin
                  beat_cnt_s = beat_cnt_r + 32'd1;
               end
            end
            ST_DONE: begin
               freq_s = 32'd0;
               done_s = 1'b1;
            end
            default: begin
               state_s    = ST_GAP;
               note_idx_s = 5'd0;
               beat_cnt_s = 32'd0;
               gap_cnt_s  = 32'd0;
               freq_s     = 32'd0;
               done_s     = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers; reset silences freq immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_GAP;
         track_r    <= 3'd0;
         note_idx_r <= 5'd0;
         beat_cnt_r <= 32'd0;
         gap_cnt_r  <= 32'd0;
         freq_r     <= 32'd0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         track_r    <= track_s;
         note_idx_r <= note_idx_s;
         beat_cnt_r <= beat_cnt_s;
         gap_cnt_r  <= gap_cnt_s;
         freq_r     <= freq_s;
         done_r     <= done_s;
      end
   end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with BEAT_CYCLES=4, GAP_BEATS=2 and a
// note ROM that answers one cycle after the address.
module tb_music_sequencer;

   logic        clk;
   logic        reset;
   logic [1:0]  scene;
   logic        boss;
   logic [7:0]  rom_addr;
   logic [31:0] rom_data;
   logic [31:0] freq;
   logic [2:0]  track;
   logic        done;

   logic [31:0] rom_mem [0:255];

   int total;
   int bad;

   typedef struct {
      logic [1:0]  scene;
      logic        boss;
      int          steps;
      logic [31:0] freq;
      logic [7:0]  addr;
      logic        chk_addr;
      logic        done;
      logic [2:0]  track;
   } vec_t;

   vec_t vecs[$];

   music_sequencer #(
      .BEAT_CYCLES(4),
      .GAP_BEATS(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .scene(scene),
      .boss(boss),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .freq(freq),
      .track(track),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: one-cycle read latency
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic add(input logic [1:0] sc, input logic bs, input int st,
                      input logic [31:0] fq, input logic [7:0] ad, input logic ca,
                      input logic dn, input logic [2:0] tr);
      vec_t v;
      v.scene = sc; v.boss = bs; v.steps = st; v.freq = fq;
      v.addr = ad; v.chk_addr = ca; v.done = dn; v.track = tr;
      vecs.push_back(v);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 256; i++) rom_mem[i] = 32'hFFFF_FFFF;
      // track 0: 440, rest, 523, EOT
      rom_mem[8'h00] = 32'd440;
      rom_mem[8'h01] = 32'd0;
      rom_mem[8'h02] = 32'd523;
      rom_mem[8'h03] = 32'hFFFF_FFFF;
      // track 1 and 4: 32 notes, no EOT
      for (int i = 0; i < 32; i++) begin
         rom_mem[8'h20 + i] = 32'd1000 + 32'(i);
         rom_mem[8'h80 + i] = 32'd2000 + 32'(i);
      end
      rom_mem[8'h40] = 32'd777;
      rom_mem[8'h41] = 32'hFFFF_FFFF;
      rom_mem[8'h60] = 32'd660;
      rom_mem[8'h61] = 32'hFFFF_FFFF;

      // scene, boss, steps, freq, addr, chk_addr, done, track
      // track 0 from reset release: gap c0..c7, FETCH c8, LOAD c9
      add(2'd0, 1'b0,   0, 32'd0,    8'h00, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   7, 32'd0,    8'h00, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   1, 32'd0,    8'h00, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   1, 32'd0,    8'h00, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   1, 32'd440,  8'h00, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   3, 32'd440,  8'h00, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   1, 32'd440,  8'h01, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   1, 32'd440,  8'h01, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   1, 32'd0,    8'h01, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   4, 32'd0,    8'h02, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   2, 32'd523,  8'h02, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   4, 32'd523,  8'h03, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   2, 32'd523,  8'h00, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   1, 32'd523,  8'h00, 1'b1, 1'b0, 3'd0);
      add(2'd0, 1'b0,   1, 32'd440,  8'h00, 1'b1, 1'b0, 3'd0);
      // win: one-shot {660, EOT}
      add(2'd2, 1'b0,   1, 32'd0,    8'h60, 1'b1, 1'b0, 3'd3);
      add(2'd2, 1'b0,   7, 32'd0,    8'h60, 1'b1, 1'b0, 3'd3);
      add(2'd2, 1'b0,   1, 32'd0,    8'h60, 1'b1, 1'b0, 3'd3);
      add(2'd2, 1'b0,   2, 32'd660,  8'h60, 1'b1, 1'b0, 3'd3);
      add(2'd2, 1'b0,   4, 32'd660,  8'h61, 1'b1, 1'b0, 3'd3);
      add(2'd2, 1'b0,   1, 32'd660,  8'h61, 1'b1, 1'b0, 3'd3);
      add(2'd2, 1'b0,   1, 32'd0,    8'h00, 1'b0, 1'b1, 3'd3);
      add(2'd2, 1'b0, 120, 32'd0,    8'h00, 1'b0, 1'b1, 3'd3);
      // leave DONE back to start
      add(2'd0, 1'b0,   1, 32'd0,    8'h00, 1'b1, 1'b0, 3'd0);
      // game track, then boss mid-beat
      add(2'd1, 1'b0,   1, 32'd0,    8'h20, 1'b1, 1'b0, 3'd1);
      add(2'd1, 1'b0,   8, 32'd0,    8'h20, 1'b1, 1'b0, 3'd1);
      add(2'd1, 1'b0,   2, 32'd1000, 8'h20, 1'b1, 1'b0, 3'd1);
      add(2'd1, 1'b0,   1, 32'd1000, 8'h20, 1'b1, 1'b0, 3'd1);
      add(2'd1, 1'b1,   1, 32'd0,    8'h40, 1'b1, 1'b0, 3'd2);
      add(2'd1, 1'b1,   7, 32'd0,    8'h40, 1'b1, 1'b0, 3'd2);
      add(2'd1, 1'b1,   1, 32'd0,    8'h40, 1'b1, 1'b0, 3'd2);
      add(2'd1, 1'b1,   2, 32'd777,  8'h40, 1'b1, 1'b0, 3'd2);
      add(2'd1, 1'b1,   6, 32'd777,  8'h40, 1'b1, 1'b0, 3'd2);
      add(2'd1, 1'b1,   2, 32'd777,  8'h40, 1'b1, 1'b0, 3'd2);
      // track 1, all 32 entries then wrap
      add(2'd1, 1'b0,   1, 32'd0,    8'h20, 1'b1, 1'b0, 3'd1);
      add(2'd1, 1'b0, 199, 32'd1031, 8'h3F, 1'b1, 1'b0, 3'd1);
      add(2'd1, 1'b0,   1, 32'd1031, 8'h20, 1'b1, 1'b0, 3'd1);
      add(2'd1, 1'b0,   2, 32'd1000, 8'h20, 1'b1, 1'b0, 3'd1);
      // track 4, all 32 entries then DONE
      add(2'd3, 1'b0,   1, 32'd0,    8'h80, 1'b1, 1'b0, 3'd4);
      add(2'd3, 1'b0, 196, 32'd2031, 8'h9F, 1'b1, 1'b0, 3'd4);
      add(2'd3, 1'b0,   3, 32'd2031, 8'h9F, 1'b1, 1'b0, 3'd4);
      add(2'd3, 1'b0,   1, 32'd0,    8'h00, 1'b0, 1'b1, 3'd4);
      add(2'd3, 1'b0,  20, 32'd0,    8'h00, 1'b0, 1'b1, 3'd4);

      // reset state
      reset = 1'b1;
      scene = 2'd0;
      boss  = 1'b0;
      step(3);
      chk("rst.freq",  freq, 32'd0);
      chk("rst.done",  {31'd0, done}, 32'd0);
      chk("rst.track", {29'd0, track}, 32'd0);
      chk("rst.addr",  {24'd0, rom_addr}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         scene = vecs[i].scene;
         boss  = vecs[i].boss;
         step(vecs[i].steps);
         chk($sformatf("vec%0d.freq", i),  freq, vecs[i].freq);
         chk($sformatf("vec%0d.done", i),  {31'd0, done}, {31'd0, vecs[i].done});
         chk($sformatf("vec%0d.track", i), {29'd0, track}, {29'd0, vecs[i].track});
         if (vecs[i].chk_addr)
            chk($sformatf("vec%0d.addr", i), {24'd0, rom_addr}, {24'd0, vecs[i].addr});
      end

      // scene glitch that returns to the same track before an edge
      scene = 2'd2;
      #1;
      scene = 2'd3;
      step(1);
      chk("glitch.track", {29'd0, track}, 32'd4);
      chk("glitch.done",  {31'd0, done}, 32'd1);
      chk("glitch.freq",  freq, 32'd0);

      // reset in the middle of the 523 note
      scene = 2'd0;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(23);
      chk("mid.freq523", freq, 32'd523);
      reset = 1'b1;
      #1;
      chk("mid.rst_freq", freq, 32'd0);
      chk("mid.rst_done", {31'd0, done}, 32'd0);
      step(2);
      chk("mid.rst_hold", freq, 32'd0);
      reset = 1'b0;
      step(7);
      chk("mid.gap7", freq, 32'd0);
      step(1);
      chk("mid.fetch_addr", {24'd0, rom_addr}, 32'h00);
      chk("mid.fetch_freq", freq, 32'd0);
      step(2);
      chk("mid.replay", freq, 32'd440);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
